cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter_if.sv | 39 +++
 rtl/cache_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Bundles the two requester ports and the cache-side request/response signals.
// slave is the arbiter's view; master is the environment (requesters plus cache).
interface cache_arbiter_if;
  logic        req0;
  logic        req1;
  logic        rw0;
  logic        rw1;
  logic [9:0]  addr0;
  logic [9:0]  addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata;

  logic        c_req;
  logic        c_rw;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata;
  logic        c_done;
  logic        c_hit;
  logic [31:0] c_rdata;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  c_done, c_hit, c_rdata,
    output ack0, ack1, err0, err1, rdata,
    output c_req, c_rw, c_addr, c_wdata
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output c_done, c_hit, c_rdata,
    input  ack0, ack1, err0, err1, rdata,
    input  c_req, c_rw, c_addr, c_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between an instruction and a data port in front of a cache,
// with a BUSY timeout and saturating hit/miss statistics.
module cache_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_arbiter_if.slave     bus,
  input  logic               clr_stats,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  // Last-grant pointer; also identifies the port being served in BUSY/RESP.
  logic        last_q, last_d;
  logic        rw_q, rw_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;
  logic        pick;

  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          last_d  = pick;
          rw_d    = pick ? bus.rw1 : bus.rw0;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.c_done) begin
          rdata_d = bus.c_rdata;
          err_d   = 1'b0;
          state_d = StResp;
          if (bus.c_hit) begin
            hit_d = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
          end else begin
            miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
          end
        end else if (wait_q == WaitLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (clr_stats) begin
      hit_d  = '0;
      miss_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.c_req   = (state_q == StBusy);
  assign bus.c_rw    = rw_q;
  assign bus.c_addr  = addr_q;
  assign bus.c_wdata = wdata_q;
  assign bus.ack0    = (state_q == StResp) && !last_q;
  assign bus.ack1    = (state_q == StResp) && last_q;
  assign bus.err0    = (state_q == StResp) && !last_q && err_q;
  assign bus.err1    = (state_q == StResp) && last_q && err_q;
  assign bus.rdata   = rdata_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard of expected acks checked by a negedge monitor.
module tb_cache_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_stats = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  cache_arbiter_if bus ();

  cache_arbiter #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_stats (clr_stats),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          r0;
    bit          r1;
    bit          rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    bit          hit;
    logic [31:0] crdata;
    int          delay;
    bit          port;
    bit          clr;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_delay = 0;
  bit          resp_hit = 1'b0;
  logic [31:0] resp_rdata = '0;
  int          busy_cyc = 0;
  int          creq_cycles = 0;
  logic [15:0] exp_hit = '0;
  logic [15:0] exp_miss = '0;
  bit          prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic expect_txn(input bit port, input bit err, input logic [31:0] rdata,
                            input bit hit);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = err ? 32'd0 : rdata;
    sb.push_back(e);
    if (!err) begin
      if (hit) exp_hit = sat_inc(exp_hit);
      else     exp_miss = sat_inc(exp_miss);
    end
  endtask

  // Cache model: answers delay cycles into BUSY; a negative delay never answers.
  always @(negedge clk) begin
    if (!rst_n || !bus.c_req) begin
      busy_cyc    = 0;
      bus.c_done  = 1'b0;
      bus.c_hit   = 1'b0;
      bus.c_rdata = '0;
    end else begin
      bus.c_done  = (done_delay >= 0) && (busy_cyc == done_delay);
      bus.c_hit   = resp_hit;
      bus.c_rdata = resp_rdata;
      busy_cyc++;
      creq_cycles++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack0 || bus.ack1) begin
        check("ack_pulse", 32'(prev_ack), 32'd0);
        check("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack0=%b ack1=%b, want no ack", bus.ack0, bus.ack1);
        end else begin
          mon_e = sb.pop_front();
          check("ack_port", 32'(bus.ack1), 32'(mon_e.port));
          check("ack_err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(mon_e.err));
          check("ack_rdata", bus.rdata, mon_e.rdata);
        end
      end
      prev_ack = bus.ack0 | bus.ack1;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic run_txn(input vec_t v);
    logic [9:0]  a1;
    logic [31:0] w1;
    logic        rw1;
    logic [9:0]  ea;
    logic [31:0] ew;
    logic        erw;
    bit          got;
    a1  = v.addr ^ 10'h3FF;
    w1  = ~v.wdata;
    rw1 = ~v.rw;
    ea  = v.port ? a1 : v.addr;
    ew  = v.port ? w1 : v.wdata;
    erw = v.port ? rw1 : v.rw;
    got = 1'b0;
    @(negedge clk);
    done_delay = v.delay;
    resp_hit   = v.hit;
    resp_rdata = v.crdata;
    bus.rw0    = v.rw;
    bus.rw1    = rw1;
    bus.addr0  = v.addr;
    bus.addr1  = a1;
    bus.wdata0 = v.wdata;
    bus.wdata1 = w1;
    bus.req0   = v.r0;
    bus.req1   = v.r1;
    expect_txn(v.port, v.delay < 0, v.crdata, v.hit);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("c_req_busy", 32'(bus.c_req), 32'd1);
        check("c_addr", 32'(bus.c_addr), 32'(ea));
        check("c_wdata", bus.c_wdata, ew);
        check("c_rw", 32'(bus.c_rw), 32'(erw));
        // Inputs may wander once granted; the cache request must not follow them.
        bus.addr0  = bus.addr0 ^ 10'h155;
        bus.addr1  = bus.addr1 ^ 10'h2AA;
        bus.wdata0 = ~bus.wdata0;
        bus.wdata1 = ~bus.wdata1;
        bus.rw0    = ~bus.rw0;
        bus.rw1    = ~bus.rw1;
        if (v.clr) clr_stats = 1'b1;
      end else if (i == 1) begin
        clr_stats = 1'b0;
        if (bus.c_req) begin
          check("c_addr_hold", 32'(bus.c_addr), 32'(ea));
          check("c_wdata_hold", bus.c_wdata, ew);
        end
      end
      if (bus.ack0 || bus.ack1) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    clr_stats = 1'b0;
    if (v.clr) begin
      exp_hit  = '0;
      exp_miss = '0;
    end
  endtask

  vec_t tbl[9];
  vec_t hv;
  int   acks;

  initial begin
    //        r0 r1 rw addr     wdata          hit crdata         dly port clr
    tbl[0] = '{1, 1, 0, 10'h010, 32'h1111_0000, 1, 32'hA0A0_0001, 1,  0, 0};
    tbl[1] = '{1, 1, 1, 10'h123, 32'h2222_0000, 0, 32'hA0A0_0002, 2,  1, 0};
    tbl[2] = '{1, 0, 0, 10'h3FF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0,  0, 0};
    tbl[3] = '{1, 0, 1, 10'h000, 32'h0000_0000, 0, 32'h1234_5678, 3,  0, 0};
    tbl[4] = '{1, 1, 0, 10'h200, 32'h8000_0001, 1, 32'hCAFE_F00D, 1,  1, 0};
    tbl[5] = '{0, 1, 1, 10'h15B, 32'h0000_0042, 1, 32'hDEAD_BEEF, 0,  1, 0};
    tbl[6] = '{1, 1, 1, 10'h0AA, 32'h5A5A_5A5A, 0, 32'h0F0F_0F0F, 4,  0, 0};
    tbl[7] = '{0, 1, 1, 10'h155, 32'hFFFF_0000, 1, 32'h1357_9BDF, 14, 1, 0};
    tbl[8] = '{1, 1, 0, 10'h2F0, 32'h7777_7777, 1, 32'h9999_9999, -1, 0, 0};

    bus.req0 = 1'b0;  bus.req1 = 1'b0;  bus.rw0 = 1'b0;  bus.rw1 = 1'b0;
    bus.addr0 = '0;   bus.addr1 = '0;   bus.wdata0 = '0; bus.wdata1 = '0;

    #3;
    check("rst_c_req", 32'(bus.c_req), 32'd0);
    check("rst_acks", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_c_addr", 32'(bus.c_addr), 32'd0);
    check("rst_c_wdata", bus.c_wdata, 32'd0);
    check("rst_c_rw", 32'(bus.c_rw), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports held: grants alternate 0,1,0,1 starting with port 0.
    @(negedge clk);
    done_delay = 1;
    resp_hit   = 1'b1;
    resp_rdata = 32'h0BAD_F00D;
    bus.addr0 = 10'h001;  bus.addr1 = 10'h002;
    bus.req0  = 1'b1;     bus.req1  = 1'b1;
    for (int k = 0; k < 4; k++) expect_txn(k[0], 1'b0, resp_rdata, 1'b1);
    acks = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("rr_acks", 32'(acks), 32'd4);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);
    check("tbl_hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    check("tbl_miss_cnt", 32'(miss_cnt), 32'(exp_miss));

    // Timeout: c_req stays up exactly TIMEOUT cycles, counters untouched.
    @(negedge clk);
    creq_cycles = 0;
    hv = '{1, 0, 1, 10'h0C3, 32'h0102_0304, 0, 32'hFFFF_FFFF, -1, 0, 0};
    run_txn(hv);
    check("to_creq_cycles", 32'(creq_cycles), 32'd15);
    check("to_hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    check("to_miss_cnt", 32'(miss_cnt), 32'(exp_miss));

    // Saturation from a preloaded miss count, then clear racing a hit.
    @(negedge clk);
    force dut.miss_q = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    release dut.miss_q;
    exp_miss = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      hv = '{1, 0, 0, 10'(i * 7), 32'(i), 0, 32'h4000_0000 + 32'(i), 0, 0, 0};
      run_txn(hv);
    end
    check("sat_miss_cnt", 32'(miss_cnt), 32'h0000_FFFF);
    hv = '{1, 0, 0, 10'h111, 32'h0, 1, 32'h5555_AAAA, 0, 0, 1};
    run_txn(hv);
    check("clr_hit_cnt", 32'(hit_cnt), 32'd0);
    check("clr_miss_cnt", 32'(miss_cnt), 32'd0);

    // Asynchronous reset mid-BUSY: no ack, and port 0 wins the next contention.
    @(negedge clk);
    done_delay = -1;
    bus.req0   = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("mid_c_req", 32'(bus.c_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_c_req", 32'(bus.c_req), 32'd0);
    check("arst_acks", 32'({bus.ack0, bus.ack1}), 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_hit_cnt", 32'(hit_cnt), 32'd0);
    hv = '{1, 1, 0, 10'h0F0, 32'hABCD_0123, 1, 32'h6666_1234, 0, 0, 0};
    run_txn(hv);
    check("post_rst_hit_cnt", 32'(hit_cnt), 32'(exp_hit));

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
